// File: rtl/toggle_cnt_pkg.sv
// Shared definitions for the toggle event counter: FSM state encoding and
// the default widths used by the top module parameters.
package toggle_cnt_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_WIN_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    COUNT  = 2'b01,
    REPORT = 2'b10
  } state_t;

endpackage

// File: rtl/toggle_edge_det.sv
// Transition detector for the toggle-stage output. The previous sample is
// kept every cycle regardless of FSM state, so the first window cycle always
// compares against the value seen in the cycle the window was opened.
module toggle_edge_det (
  input  logic clk,
  input  logic clr,
  input  logic t_in,
  output logic t_edge
);

  logic t_prev;

  // Register the toggle input every cycle; cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (clr) begin
      t_prev <= 1'b0;
    end else begin
      t_prev <= t_in;
    end
  end

  assign t_edge = t_in ^ t_prev;

endmodule

// File: rtl/toggle_event_counter.sv
// Counts transitions of a toggle-stage output over a programmable window of
// clk cycles and hands the result to a consumer through a valid/ready pair.
// The count saturates; an edge arriving while saturated raises ovf.
module toggle_event_counter
  import toggle_cnt_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int WIN_W = DEF_WIN_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             t_in,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             ovf,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIN_W-1:0] WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_next;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] count;
  logic             ovf_q;
  logic             t_edge;
  logic             handshake;
  logic             start_win;
  logic             last_cycle;

  toggle_edge_det u_edge_det (
    .clk    (clk),
    .clr    (clr),
    .t_in   (t_in),
    .t_edge (t_edge)
  );

  // A window opens from IDLE, or straight out of REPORT when the result is
  // taken in the same cycle start is raised, giving back-to-back windows.
  assign handshake  = (state == REPORT) && cnt_ready;
  assign start_win  = start && ((state == IDLE) || handshake);
  assign last_cycle = (state == COUNT) && (win_cnt <= WIN_ONE);

  // State register.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start is only looked at in IDLE and on the handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = COUNT;
        end
      end
      COUNT: begin
        if (last_cycle) begin
          state_next = REPORT;
        end
      end
      REPORT: begin
        if (cnt_ready) begin
          state_next = start ? COUNT : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    cnt_valid = 1'b0;
    busy      = 1'b0;
    if (state == REPORT) begin
      cnt_valid = 1'b1;
    end
    if (state != IDLE) begin
      busy = 1'b1;
    end
  end

  // Window counter and saturating edge count; frozen outside COUNT so the
  // reported value stays put while the consumer back-pressures.
  always_ff @(posedge clk) begin
    if (clr) begin
      win_cnt <= '0;
      count   <= '0;
      ovf_q   <= 1'b0;
    end else if (start_win) begin
      win_cnt <= (win_len == '0) ? WIN_ONE : win_len;
      count   <= '0;
      ovf_q   <= 1'b0;
    end else if (state == COUNT) begin
      win_cnt <= win_cnt - WIN_ONE;
      if (t_edge) begin
        if (count == CNT_MAX) begin
          ovf_q <= 1'b1;
        end else begin
          count <= count + CNT_ONE;
        end
      end
    end
  end

  assign cnt_out = count;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_toggle_event_counter.sv
// Directed bench for toggle_event_counter. Two instances share the stimulus:
// one at the default width and one with a 4-bit count to reach saturation.
// Expected results are computed from the driven toggle pattern, queued when a
// window finishes and popped when the result appears.
module tb_toggle_event_counter;

  typedef struct {
    int cnt;
    bit ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr;
  logic       t_in;
  logic       start;
  logic [7:0] win_len;
  logic       cnt_ready;

  logic [7:0] cnt_out8;
  logic       cnt_valid8;
  logic       ovf8;
  logic       busy8;
  logic [3:0] cnt_out4;
  logic       cnt_valid4;
  logic       ovf4;
  logic       busy4;

  int   tests_run = 0;
  int   failures  = 0;
  exp_t q8[$];
  exp_t q4[$];
  exp_t held8;
  exp_t held4;

  toggle_event_counter #(.CNT_W(8), .WIN_W(8)) dut (
    .clk       (clk),
    .clr       (clr),
    .t_in      (t_in),
    .start     (start),
    .win_len   (win_len),
    .cnt_out   (cnt_out8),
    .cnt_valid (cnt_valid8),
    .cnt_ready (cnt_ready),
    .ovf       (ovf8),
    .busy      (busy8)
  );

  toggle_event_counter #(.CNT_W(4), .WIN_W(8)) dut4 (
    .clk       (clk),
    .clr       (clr),
    .t_in      (t_in),
    .start     (start),
    .win_len   (win_len),
    .cnt_out   (cnt_out4),
    .cnt_valid (cnt_valid4),
    .cnt_ready (cnt_ready),
    .ovf       (ovf4),
    .busy      (busy4)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Safety net so a stuck run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one cycle; inputs set afterwards apply to the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expect(input int edges);
    exp_t e;
    e.cnt = (edges > 255) ? 255 : edges;
    e.ovf = (edges > 255);
    q8.push_back(e);
    e.cnt = (edges > 15) ? 15 : edges;
    e.ovf = (edges > 15);
    q4.push_back(e);
  endtask

  task automatic open_window(input logic [7:0] wl);
    start   = 1'b1;
    win_len = wl;
    step();
    start   = 1'b0;
  endtask

  // Drives window cycles 1..eff, toggling t_in every 'period' cycles and
  // counting the transitions; optionally asserts clr in cycle abort_at.
  task automatic applyStimulus(input int eff, input int period,
                               input int abort_at, input bit hold_start);
    int   edges = 0;
    logic nxt;
    if (hold_start) begin
      win_len = 8'd3;
    end
    for (int k = 1; k <= eff; k++) begin
      start = hold_start;
      nxt = (period > 0 && (k % period) == 0) ? ~t_in : t_in;
      if (nxt !== t_in) begin
        edges++;
      end
      t_in = nxt;
      if (k == abort_at) begin
        clr = 1'b1;
        step();
        clr   = 1'b0;
        start = 1'b0;
        return;
      end
      if (k == eff) begin
        check("valid_in_last_window_cycle", cnt_valid8, 1'b0);
        check("busy_in_last_window_cycle", busy8, 1'b1);
      end
      step();
    end
    start = 1'b0;
    push_expect(edges);
  endtask

  task automatic checkOutput();
    check("valid8_after_window", cnt_valid8, 1'b1);
    check("valid4_after_window", cnt_valid4, 1'b1);
    if (q8.size() == 0 || q4.size() == 0) begin
      tests_run++;
      failures++;
      $error("[TB] FAIL scoreboard: observed result, expected none queued");
    end else begin
      held8 = q8.pop_front();
      held4 = q4.pop_front();
      check("cnt8", cnt_out8, held8.cnt);
      check("ovf8", ovf8, held8.ovf);
      check("cnt4", cnt_out4, held4.cnt);
      check("ovf4", ovf4, held4.ovf);
    end
  endtask

  task automatic handshake_idle();
    cnt_ready = 1'b1;
    step();
    cnt_ready = 1'b0;
    check("busy8_after_handshake", busy8, 1'b0);
    check("valid8_after_handshake", cnt_valid8, 1'b0);
    check("busy4_after_handshake", busy4, 1'b0);
  endtask

  initial begin
    clr       = 1'b1;
    t_in      = 1'b0;
    start     = 1'b0;
    win_len   = 8'd0;
    cnt_ready = 1'b0;

    // Reset held for two cycles while t_in toggles.
    step();
    t_in = 1'b1;
    step();
    t_in = 1'b0;
    check("rst_cnt8", cnt_out8, 8'd0);
    check("rst_valid8", cnt_valid8, 1'b0);
    check("rst_ovf8", ovf8, 1'b0);
    check("rst_busy8", busy8, 1'b0);
    check("rst_cnt4", cnt_out4, 4'd0);
    clr = 1'b0;
    step();

    // Basic 20-cycle window, toggle every 2 cycles, start held during COUNT.
    open_window(8'd20);
    applyStimulus(20, 2, 0, 1'b1);
    checkOutput();

    // Back-pressure in REPORT while t_in keeps toggling.
    for (int i = 0; i < 5; i++) begin
      t_in = ~t_in;
      step();
      check("bp_valid8", cnt_valid8, 1'b1);
      check("bp_cnt8", cnt_out8, held8.cnt);
      check("bp_ovf8", ovf8, held8.ovf);
      check("bp_cnt4", cnt_out4, held4.cnt);
    end
    handshake_idle();
    step();

    // Saturation window: 40 toggles; the 4-bit instance saturates.
    open_window(8'd40);
    applyStimulus(40, 1, 0, 1'b1);
    checkOutput();

    // Start held through the handshake with win_len=0: next window is 1 cycle.
    start     = 1'b1;
    win_len   = 8'd0;
    cnt_ready = 1'b1;
    step();
    start     = 1'b0;
    cnt_ready = 1'b0;
    check("b2b_busy8", busy8, 1'b1);
    check("b2b_valid8", cnt_valid8, 1'b0);
    check("b2b_cnt8", cnt_out8, 8'd0);
    check("b2b_ovf4_cleared", ovf4, 1'b0);
    applyStimulus(1, 1, 0, 1'b0);
    checkOutput();
    handshake_idle();
    step();

    // Abort in cycle 5 of a 20-cycle window.
    open_window(8'd20);
    applyStimulus(20, 1, 5, 1'b0);
    check("abort_cnt8", cnt_out8, 8'd0);
    check("abort_valid8", cnt_valid8, 1'b0);
    check("abort_ovf8", ovf8, 1'b0);
    check("abort_busy8", busy8, 1'b0);
    check("abort_cnt4", cnt_out4, 4'd0);
    step();
    check("abort_no_result", cnt_valid8, 1'b0);

    // Short window after the abort, two toggles.
    open_window(8'd4);
    applyStimulus(4, 2, 0, 1'b0);
    checkOutput();
    handshake_idle();

    // Odd-length window with a sparse pattern.
    open_window(8'd7);
    applyStimulus(7, 3, 0, 1'b0);
    checkOutput();
    handshake_idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
